master_port: RTL and testbench

- Serial-bus master interface. Sits between a parallel master device and the shared serial bus, directly upstream of the slave port.
- Accepts one parallel read/write request and obtains the bus from the arbiter.
- Serializes address then write data LSB-first with mvalid, or deserializes read data qualified by svalid.
- Tolerates split transactions and reports completion or timeout back to the device.

---
 rtl/master_port.sv | 207 ++++++++++++++++++++
 tb/tb_master_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// master_port: serial-bus master. Takes one parallel read/write request from a
// device, wins the bus from the arbiter, shifts the address (and write data)
// out LSB-first under mvalid, and assembles read data qualified by svalid,
// surviving slave splits and aborting with an error on a response timeout.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   dreq, dmode, daddr, dwdata     device request (sampled in IDLE only)
//   dready                         port idle, decoded from state
//   ddone, derr, drdata            completion pulse, timeout flag, read word
//   mbreq / mbgrant                arbiter handshake
//   mwdata, mmode, mvalid          serial address/data to the slave
//   mrdata, svalid, sready, ssplit serial read data and slave status
module master_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dreq,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic                  ddone,
  output logic                  derr,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  mrdata,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit
);

  localparam int unsigned MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, WRESP, RWAIT, SPLIT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  // Holds the first DATA_WIDTH-1 read bits; the final bit joins on completion.
  logic [DATA_WIDTH-2:0]   rbuf_q, rbuf_d;
  logic                    ddone_d, derr_d, mbreq_d, mwdata_d, mmode_d, mvalid_d;
  logic [DATA_WIDTH-1:0]   drdata_d;

  // Gated with rstn so dready reads 0 while reset is asserted.
  assign dready = rstn && (state_q == IDLE);

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      ddone   <= 1'b0;
      derr    <= 1'b0;
      drdata  <= '0;
      mbreq   <= 1'b0;
      mwdata  <= 1'b0;
      mmode   <= 1'b0;
      mvalid  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      ddone   <= ddone_d;
      derr    <= derr_d;
      drdata  <= drdata_d;
      mbreq   <= mbreq_d;
      mwdata  <= mwdata_d;
      mmode   <= mmode_d;
      mvalid  <= mvalid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    ddone_d  = 1'b0;
    derr_d   = 1'b0;
    drdata_d = drdata;
    mbreq_d  = mbreq;
    mwdata_d = 1'b0;
    mmode_d  = mmode;
    mvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dreq) begin
          addr_d  = daddr;
          wdata_d = dwdata;
          mmode_d = dmode;
          mbreq_d = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      // Bit 0 is presented on the edge that enters ADDR.
      REQ: begin
        if (mbgrant && sready) begin
          mvalid_d = 1'b1;
          mwdata_d = addr_q[0];
          addr_d   = ADDR_WIDTH'(addr_q >> 1);
          cnt_d    = '0;
          state_d  = ADDR;
        end
      end

      // cnt_q is the index of the bit currently on mwdata.
      ADDR: begin
        if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
          cnt_d = '0;
          if (mmode) begin
            mvalid_d = 1'b1;
            mwdata_d = wdata_q[0];
            wdata_d  = DATA_WIDTH'(wdata_q >> 1);
            state_d  = WDATA;
          end else begin
            tcnt_d  = '0;
            state_d = RWAIT;
          end
        end else begin
          mvalid_d = 1'b1;
          mwdata_d = addr_q[0];
          addr_d   = ADDR_WIDTH'(addr_q >> 1);
          cnt_d    = cnt_q + CW'(1);
        end
      end

      WDATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = WRESP;
        end else begin
          mvalid_d = 1'b1;
          mwdata_d = wdata_q[0];
          wdata_d  = DATA_WIDTH'(wdata_q >> 1);
          cnt_d    = cnt_q + CW'(1);
        end
      end

      // The slave still shows its stale sready on the first cycle; skip it.
      WRESP: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (sready) begin
          ddone_d = 1'b1;
          mbreq_d = 1'b0;
          state_d = IDLE;
        end
      end

      // Capture is identical before and after a split; svalid beats ssplit.
      RWAIT, SPLIT: begin
        if (svalid) begin
          tcnt_d = '0;
          rbuf_d = {mrdata, rbuf_q[DATA_WIDTH-2:1]};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            drdata_d = {mrdata, rbuf_q};
            ddone_d  = 1'b1;
            mbreq_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          tcnt_d  = TW'(TIMEOUT);
          ddone_d = 1'b1;
          derr_d  = 1'b1;
          mbreq_d = 1'b0;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (state_q == RWAIT && ssplit) begin
            mbreq_d = 1'b0;
            state_d = SPLIT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port. u_dut runs with the default timeout; u_to
// shares its inputs with TIMEOUT=16 and is only inspected for timeout cases.
module tb_master_port;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dreq, dmode;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        mbgrant, mrdata, svalid, sready, ssplit;

  logic        dready, ddone, derr, mbreq, mwdata, mmode, mvalid;
  logic [7:0]  drdata;
  logic        dready_t, ddone_t, derr_t, mbreq_t, mwdata_t, mmode_t, mvalid_t;
  logic [7:0]  drdata_t;

  int errors = 0;
  int checks = 0;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(255)) u_dut (
    .clk(clk), .rstn(rstn), .dreq(dreq), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .dready(dready), .ddone(ddone), .derr(derr),
    .drdata(drdata), .mbreq(mbreq), .mbgrant(mbgrant), .mwdata(mwdata),
    .mmode(mmode), .mvalid(mvalid), .mrdata(mrdata), .svalid(svalid),
    .sready(sready), .ssplit(ssplit)
  );

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(16)) u_to (
    .clk(clk), .rstn(rstn), .dreq(dreq), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .dready(dready_t), .ddone(ddone_t), .derr(derr_t),
    .drdata(drdata_t), .mbreq(mbreq_t), .mbgrant(mbgrant), .mwdata(mwdata_t),
    .mmode(mmode_t), .mvalid(mvalid_t), .mrdata(mrdata), .svalid(svalid),
    .sready(sready), .ssplit(ssplit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic mode, input logic [11:0] a, input logic [7:0] d);
    dreq   = 1'b1;
    dmode  = mode;
    daddr  = a;
    dwdata = d;
    tick();
    dreq   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!ddone && n < bound) begin
      tick();
      n++;
    end
    check(tag, ddone, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic [7:0]  w;
    logic [7:0]  r;

    rstn = 1'b0; dreq = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
    mbgrant = 1'b0; mrdata = 1'b0; svalid = 1'b0; sready = 1'b0; ssplit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dready", dready, 0);
    check("rst_mbreq", mbreq, 0);
    check("rst_mvalid", mvalid, 0);
    check("rst_drdata", drdata, 0);
    rstn = 1'b1;
    tick();
    check("idle_dready", dready, 1);

    // Write 0xA5C <- 0x3B, immediate grant
    mbgrant = 1'b1; sready = 1'b1;
    a = 12'hA5C; w = 8'h3B;
    start(1'b1, a, w);
    check("wr_mbreq", mbreq, 1);
    check("wr_dready_busy", dready, 0);
    check("wr_mmode", mmode, 1);
    check("wr_mvalid_req", mvalid, 0);
    tick();
    sready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("wr_addr_valid", mvalid, 1);
      check("wr_addr_bit", mwdata, a[i]);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check("wr_data_valid", mvalid, 1);
      check("wr_data_bit", mwdata, w[i]);
      tick();
    end
    check("wr_resp_mvalid", mvalid, 0);
    tick();
    tick();
    check("wr_no_early_done", ddone, 0);
    sready = 1'b1;
    tick();
    check("wr_done", ddone, 1);
    check("wr_derr", derr, 0);
    check("wr_mbreq_drop", mbreq, 0);
    check("wr_dready_back", dready, 1);
    tick();
    check("wr_done_pulse", ddone, 0);

    // Reset while bit 5 of the address is on the wire
    start(1'b1, 12'h020, 8'h55);
    tick();
    repeat (5) tick();
    check("rs_bit5_valid", mvalid, 1);
    check("rs_bit5", mwdata, 1);
    rstn = 1'b0;
    #1;
    check("rs_mvalid", mvalid, 0);
    check("rs_mwdata", mwdata, 0);
    check("rs_mbreq", mbreq, 0);
    check("rs_mmode", mmode, 0);
    check("rs_dready", dready, 0);
    check("rs_ddone", ddone, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("rs_dready_release", dready, 1);
    for (int i = 0; i < 3; i++) begin
      check("rs_no_done", ddone, 0);
      tick();
    end

    // Read 0x012 -> 0xC6, no split
    sready = 1'b1;
    start(1'b0, 12'h012, 8'h00);
    check("rd_mmode", mmode, 0);
    tick();
    a = 12'h012;
    for (int i = 0; i < 12; i++) begin
      check("rd_addr_bit", mwdata, a[i]);
      tick();
    end
    check("rd_wait_mvalid", mvalid, 0);
    r = 8'hC6;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1;
      mrdata = r[i];
      check("rd_no_early_done", ddone, 0);
      tick();
    end
    svalid = 1'b0; mrdata = 1'b0;
    check("rd_done", ddone, 1);
    check("rd_data", drdata, 8'hC6);
    check("rd_derr", derr, 0);
    check("rd_mbreq_drop", mbreq, 0);
    tick();
    check("rd_done_pulse", ddone, 0);
    check("rd_data_held", drdata, 8'hC6);

    // Split read 0x7F0 -> 0x81, resent after 20 idle cycles with gaps
    start(1'b0, 12'h7F0, 8'h00);
    tick();
    repeat (12) tick();
    check("sp_mbreq_wait", mbreq, 1);
    repeat (3) tick();
    ssplit = 1'b1;
    tick();
    ssplit = 1'b0;
    check("sp_mbreq_drop", mbreq, 0);
    repeat (20) tick();
    check("sp_no_done_idle", ddone, 0);
    r = 8'h81;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1;
      mrdata = r[i];
      tick();
      svalid = 1'b0;
      mrdata = 1'b0;
      if (i != 7) begin
        check("sp_no_done_gap", ddone, 0);
        tick();
      end
    end
    check("sp_done", ddone, 1);
    check("sp_data", drdata, 8'h81);
    check("sp_derr", derr, 0);
    check("sp_to_data_kept", drdata_t, 8'hC6);
    tick();

    // Grant held low for 10 cycles
    mbgrant = 1'b0;
    start(1'b1, 12'h001, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      check("gd_mvalid_low", mvalid, 0);
      check("gd_mbreq_high", mbreq, 1);
      tick();
    end
    mbgrant = 1'b1;
    check("gd_mvalid_pre", mvalid, 0);
    tick();
    check("gd_addr_start", mvalid, 1);
    check("gd_addr_bit0", mwdata, 1);
    wait_done("gd_done", 40);
    check("gd_derr", derr, 0);
    tick();

    // Timeout read on the TIMEOUT=16 instance
    start(1'b0, 12'h0F0, 8'h00);
    tick();
    repeat (12) tick();
    for (int k = 1; k <= 16; k++) begin
      check("to_no_done", ddone_t, 0);
      tick();
    end
    check("to_done", ddone_t, 1);
    check("to_derr", derr_t, 1);
    check("to_data_kept", drdata_t, 8'hC6);
    check("to_mbreq_drop", mbreq_t, 0);
    check("to_long_still_wait", ddone, 0);
    check("to_long_mbreq", mbreq, 1);
    tick();
    check("to_done_pulse", ddone_t, 0);
    check("to_dready", dready_t, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
